// File: rtl/pip_stage_chain.sv
// Writeback pipeline of DEPTH stages with per-stage valid, global stall/flush and a
// forwarding lookup that returns the youngest in-flight write to a queried register.
module pip_stage_chain #(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned DEPTH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic [AW-1:0] in_rd_ad,
    input  logic          in_rdEn,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_rd_ad,
    output logic          out_rdEn,
    input  logic [AW-1:0] fwd_rs_ad,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data
);

    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [DEPTH-1:0]         rden_q, rden_d;
    logic [DEPTH-1:0][DW-1:0] data_q, data_d;
    logic [DEPTH-1:0][AW-1:0] rd_q, rd_d;

    // Flush only kills valids; payload is left in place since bubbles ignore it.
    always_comb begin
        valid_d = valid_q;
        rden_d  = rden_q;
        data_d  = data_q;
        rd_d    = rd_q;
        if (flush) begin
            valid_d = '0;
        end else if (!stall) begin
            valid_d[0] = in_valid;
            rden_d[0]  = in_rdEn;
            data_d[0]  = in_data;
            rd_d[0]    = in_rd_ad;
            for (int k = 1; k < int'(DEPTH); k++) begin
                valid_d[k] = valid_q[k-1];
                rden_d[k]  = rden_q[k-1];
                data_d[k]  = data_q[k-1];
                rd_d[k]    = rd_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rden_q  <= '0;
            data_q  <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            rden_q  <= rden_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign out_rd_ad = rd_q[DEPTH-1];
    assign out_rdEn  = valid_q[DEPTH-1] & rden_q[DEPTH-1];

    // Scan oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (valid_q[k] && rden_q[k] && (rd_q[k] == fwd_rs_ad) && (fwd_rs_ad != '0)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[k];
            end
        end
    end

endmodule

// File: tb/tb_pip_stage_chain.sv
// Randomised and directed bench for pip_stage_chain against a queue-based reference model.
module tb_pip_stage_chain;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [AW-1:0] in_rd_ad = '0;
    logic          in_rdEn = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_rd_ad;
    logic          out_rdEn;
    logic [AW-1:0] fwd_rs_ad = '0;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          v;
        bit [DW-1:0] d;
        bit [AW-1:0] a;
        bit          e;
    } ent_t;

    // Index 0 is the youngest entry, the last index is what the register file sees.
    ent_t mdl[$];

    pip_stage_chain #(
        .DW   (DW),
        .AW   (AW),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_rd_ad (in_rd_ad),
        .in_rdEn  (in_rdEn),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_rd_ad(out_rd_ad),
        .out_rdEn (out_rdEn),
        .fwd_rs_ad(fwd_rs_ad),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        ent_t z;
        z = '{v: 1'b0, d: '0, a: '0, e: 1'b0};
        mdl.delete();
        for (int i = 0; i < int'(DEPTH); i++) mdl.push_back(z);
    endtask

    task automatic model_edge();
        ent_t n;
        if (flush) begin
            foreach (mdl[i]) mdl[i].v = 1'b0;
        end else if (!stall) begin
            n = '{v: in_valid, d: in_data, a: in_rd_ad, e: in_rdEn};
            mdl.push_front(n);
            void'(mdl.pop_back());
        end
    endtask

    task automatic compare_all();
        ent_t  o;
        bit    hit;
        bit [DW-1:0] fd;
        o   = mdl[DEPTH-1];
        hit = 1'b0;
        fd  = '0;
        for (int i = 0; i < mdl.size(); i++) begin
            if (!hit && mdl[i].v && mdl[i].e && mdl[i].a == fwd_rs_ad && fwd_rs_ad != 0) begin
                hit = 1'b1;
                fd  = mdl[i].d;
            end
        end
        check_eq("out_valid", 64'(out_valid), 64'(o.v));
        check_eq("out_rdEn", 64'(out_rdEn), 64'(o.v & o.e));
        if (o.v) begin
            check_eq("out_data", 64'(out_data), 64'(o.d));
            check_eq("out_rd_ad", 64'(out_rd_ad), 64'(o.a));
        end
        check_eq("fwd_hit", 64'(fwd_hit), 64'(hit));
        check_eq("fwd_data", 64'(fwd_data), 64'(fd));
    endtask

    task automatic cycle(input bit v, input bit [DW-1:0] d, input bit [AW-1:0] a, input bit e,
                         input bit st, input bit fl, input bit [AW-1:0] rs);
        in_valid  = v;
        in_data   = d;
        in_rd_ad  = a;
        in_rdEn   = e;
        stall     = st;
        flush     = fl;
        fwd_rs_ad = rs;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Called just after a sampling point; asserts reset between edges.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data", 64'(out_data), 64'd0);
        check_eq("rst_out_rd_ad", 64'(out_rd_ad), 64'd0);
        check_eq("rst_out_rdEn", 64'(out_rdEn), 64'd0);
        check_eq("rst_fwd_hit", 64'(fwd_hit), 64'd0);
        check_eq("rst_fwd_data", 64'(fwd_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-stream, then a fresh write emerges after exactly DEPTH edges.
        cycle(1, 32'h1, 5'd1, 1, 0, 0, 5'd1);
        cycle(1, 32'h2, 5'd2, 1, 0, 0, 5'd2);
        cycle(1, 32'h3, 5'd3, 1, 0, 0, 5'd3);
        fwd_rs_ad = 5'd2;
        async_reset();
        cycle(1, 32'hA5A5A5A5, 5'd7, 1, 0, 0, 5'd7);
        cycle(0, 32'h0, 5'd0, 0, 0, 0, 5'd7);
        check_eq("lat_not_early", 64'(out_valid), 64'd0);
        cycle(0, 32'h0, 5'd0, 0, 0, 0, 5'd7);
        check_eq("lat_a5_data", 64'(out_data), 64'hA5A5A5A5);
        check_eq("lat_a5_rd", 64'(out_rd_ad), 64'd7);
        check_eq("lat_a5_en", 64'(out_rdEn), 64'd1);

        // Ordering.
        cycle(1, 32'h11, 5'd1, 1, 0, 0, 5'd0);
        cycle(1, 32'h22, 5'd2, 1, 0, 0, 5'd0);
        cycle(1, 32'h33, 5'd3, 1, 0, 0, 5'd0);
        check_eq("ord_11", 64'(out_data), 64'h11);
        cycle(0, 32'h0, 5'd0, 0, 0, 0, 5'd0);
        check_eq("ord_22", 64'(out_data), 64'h22);
        cycle(0, 32'h0, 5'd0, 0, 0, 0, 5'd0);
        check_eq("ord_33", 64'(out_data), 64'h33);

        // Stall freezes contents; in_* ignored while stalled.
        cycle(1, 32'h44, 5'd4, 1, 0, 0, 5'd4);
        repeat (3) cycle(1, 32'h99, 5'd9, 1, 1, 0, 5'd9);
        check_eq("stall_no99", 64'(fwd_hit), 64'd0);
        cycle(0, 32'h0, 5'd0, 0, 0, 0, 5'd4);
        cycle(0, 32'h0, 5'd0, 0, 0, 0, 5'd4);
        check_eq("stall_44_out", 64'(out_data), 64'h44);
        check_eq("stall_44_en", 64'(out_rdEn), 64'd1);

        // Flush wins over stall.
        cycle(1, 32'h55, 5'd5, 1, 0, 0, 5'd5);
        cycle(1, 32'h66, 5'd6, 1, 0, 0, 5'd5);
        cycle(1, 32'h77, 5'd7, 1, 1, 1, 5'd5);
        check_eq("flush_valid", 64'(out_valid), 64'd0);
        check_eq("flush_hit", 64'(fwd_hit), 64'd0);

        // Youngest match wins.
        cycle(1, 32'h100, 5'd5, 1, 0, 0, 5'd5);
        cycle(0, 32'h0, 5'd0, 0, 0, 0, 5'd5);
        cycle(1, 32'h200, 5'd5, 1, 0, 0, 5'd5);
        check_eq("fwd_prio_hit", 64'(fwd_hit), 64'd1);
        check_eq("fwd_prio_data", 64'(fwd_data), 64'h200);

        // x0 never hits; rdEn=0 or valid=0 never hits.
        cycle(1, 32'h55, 5'd0, 1, 0, 0, 5'd0);
        check_eq("fwd_x0", 64'(fwd_hit), 64'd0);
        cycle(1, 32'h66, 5'd6, 0, 0, 0, 5'd6);
        cycle(0, 32'h67, 5'd6, 1, 0, 0, 5'd6);
        check_eq("fwd_nohit", 64'(fwd_hit), 64'd0);
        check_eq("fwd_nodata", 64'(fwd_data), 64'd0);

        // Random traffic with occasional asynchronous reset.
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 15) == 0, 5'($urandom_range(0, 7)));
            if ($urandom_range(0, 99) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
